acumulador_multicanal: RTL and testbench

//  Multi-channel signed accumulator for the filter datapath: sums signed products per channel,

---
 rtl/acumulador_multicanal_if.sv | 39 +++
 rtl/acumulador_multicanal.sv | 187 ++++++++++++++++++
 tb/tb_acumulador_multicanal.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acumulador_multicanal_if.sv
// -----------------------------------------------------------------------------
// acumulador_multicanal_if
// Bundles the sample-input, dump-request and readout signals of the
// multi-channel accumulator.
//   master : the producer/consumer side (multiplier stage + output formatter)
//   slave  : the accumulator itself
// Parameters mirror the accumulator: W (sample width), NUM_CH (channels),
// GUARD (extra MSBs, AW = W + GUARD).
// -----------------------------------------------------------------------------
interface acumulador_multicanal_if #(
  parameter int W      = 50,
  parameter int NUM_CH = 4,
  parameter int GUARD  = 4
);
  localparam int AW  = W + GUARD;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic           in_valid;
  logic [CHW-1:0] in_ch;
  logic           in_load;
  logic [W-1:0]   in_data;
  logic           dump_req;
  logic           out_valid;
  logic           out_ready;
  logic [CHW-1:0] out_ch;
  logic [AW-1:0]  out_data;
  logic           busy;
  logic           sat_flag;

  modport master (
    output in_valid, in_ch, in_load, in_data, dump_req, out_ready,
    input  out_valid, out_ch, out_data, busy, sat_flag
  );

  modport slave (
    input  in_valid, in_ch, in_load, in_data, dump_req, out_ready,
    output out_valid, out_ch, out_data, busy, sat_flag
  );
endinterface

// File: rtl/acumulador_multicanal.sv
// -----------------------------------------------------------------------------
// acumulador_multicanal
// Multi-channel signed accumulator. Each channel loads or adds sign-extended
// samples; a dump request serialises every channel total, channel 0 first,
// through a valid/ready port.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high, clears accumulators, FSM and outputs
//   bus   : acumulador_multicanal_if.slave (sample in, dump_req, readout out,
//           busy, sat_flag)
// Build option: define ACUMULADOR_SAT_EN to clamp additions to the AW-bit
// signed range and raise a sticky sat_flag; without it sums wrap and
// sat_flag is constant 0.
// -----------------------------------------------------------------------------
module acumulador_multicanal #(
  parameter int W           = 50,
  parameter int NUM_CH      = 4,
  parameter int GUARD       = 4,
  parameter int CLR_ON_DUMP = 1
) (
  input logic                    clk,
  input logic                    reset,
  acumulador_multicanal_if.slave bus
);
  localparam int AW  = W + GUARD;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // One extra bit so the range check is meaningful for power-of-two NUM_CH
  localparam logic [CHW:0]   NUM_CH_W = (CHW+1)'(NUM_CH);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DUMP = 1'b1;

`ifdef ACUMULADOR_SAT_EN
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
`endif

  logic [0:0]           state_r;
  logic signed [AW-1:0] acc_r      [NUM_CH];
  logic signed [AW-1:0] acc_next_s [NUM_CH];
  logic signed [AW-1:0] sample_s;
  logic signed [AW-1:0] cur_s;
  logic signed [AW-1:0] upd_s;
  logic                 ch_ok_s;
  logic                 take_s;
  logic                 xfer_s;
  logic                 last_s;
  logic [CHW-1:0]       nxt_ch_s;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [CHW-1:0]       out_ch_r;
  logic signed [AW-1:0] out_data_r;
`ifdef ACUMULADOR_SAT_EN
  logic [AW:0]          wide_s;
  logic                 sat_set_s;
  logic                 sat_r;
`endif

  assign sample_s = AW'($signed(bus.in_data));
  assign ch_ok_s  = {1'b0, bus.in_ch} < NUM_CH_W;
  // Samples are only taken in IDLE; anything arriving during a dump is lost
  assign take_s   = (state_r == ST_IDLE) && bus.in_valid && ch_ok_s;
  assign xfer_s   = (state_r == ST_DUMP) && out_valid_r && bus.out_ready;
  assign last_s   = (out_ch_r == LAST_CH);
  assign nxt_ch_s = out_ch_r + CHW'(1);
  assign cur_s    = ch_ok_s ? acc_r[bus.in_ch] : '0;

  // Update value for the addressed channel: load, or add with wrap/clamp
  always_comb begin
    upd_s = sample_s;
`ifdef ACUMULADOR_SAT_EN
    wide_s    = '0;
    sat_set_s = 1'b0;
`endif
    if (bus.in_load) begin
      upd_s = sample_s;
    end else begin
`ifdef ACUMULADOR_SAT_EN
      wide_s = {cur_s[AW-1], cur_s} + {sample_s[AW-1], sample_s};
      // Overflow when the two top bits of the extended sum disagree
      if (wide_s[AW] != wide_s[AW-1]) begin
        upd_s     = wide_s[AW] ? ACC_MIN : ACC_MAX;
        sat_set_s = 1'b1;
      end else begin
        upd_s = wide_s[AW-1:0];
      end
`else
      upd_s = cur_s + sample_s;
`endif
    end
  end

  // Next accumulator contents: sample write in IDLE, optional clear on beat
  always_comb begin
    acc_next_s = acc_r;
    if (take_s) begin
      acc_next_s[bus.in_ch] = upd_s;
    end else if (xfer_s && (CLR_ON_DUMP != 0)) begin
      acc_next_s[out_ch_r] = '0;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Accumulator storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i] <= '0;
      end
    end else begin
      acc_r <= acc_next_s;
    end
  end

  // Readout FSM and registered output beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_ch_r    <= '0;
      out_data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.dump_req) begin
            // acc_next_s so a same-cycle sample to channel 0 is reported
            state_r     <= ST_DUMP;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            out_ch_r    <= '0;
            out_data_r  <= acc_next_s[0];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DUMP: begin
          if (xfer_s) begin
            if (last_s) begin
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
            end else begin
              out_ch_r   <= nxt_ch_s;
              out_data_r <= acc_r[nxt_ch_s];
            end
          end else begin
            state_r <= ST_DUMP;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          out_ch_r    <= '0;
          out_data_r  <= '0;
        end
      endcase
    end
  end

`ifdef ACUMULADOR_SAT_EN
  // Sticky clamp indicator, cleared when the last beat of a dump is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_r <= 1'b0;
    end else if (take_s && sat_set_s) begin
      sat_r <= 1'b1;
    end else if (xfer_s && last_s) begin
      sat_r <= 1'b0;
    end else begin
      sat_r <= sat_r;
    end
  end

  assign bus.sat_flag = sat_r;
`else
  assign bus.sat_flag = 1'b0;
`endif

  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_data  = out_data_r;
endmodule

// File: tb/tb_acumulador_multicanal.sv
// -----------------------------------------------------------------------------
// tb_acumulador_multicanal
// Two accumulator instances: u0 (W=50, NUM_CH=4, GUARD=4) and u1 (W=8,
// NUM_CH=3, GUARD=0, used for overflow and out-of-range channel cases).
// A reference model keeps per-channel totals as plain integers and, on a dump,
// snapshots all totals into the list of beats that must appear in order.
// -----------------------------------------------------------------------------
module tb_acumulador_multicanal;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Stimulus per instance
  logic        iv   [NI];
  logic [1:0]  ich  [NI];
  logic        ild  [NI];
  logic [49:0] idat [NI];
  logic        dreq [NI];
  logic        ordy [NI];
  // Observed outputs per instance
  logic        ov    [NI];
  logic [1:0]  och   [NI];
  longint      odat  [NI];
  logic        obusy [NI];
  logic        osat  [NI];

  acumulador_multicanal_if #(.W(50), .NUM_CH(4), .GUARD(4)) bus0 ();
  acumulador_multicanal_if #(.W(8),  .NUM_CH(3), .GUARD(0)) bus1 ();

  assign bus0.in_valid  = iv[0];
  assign bus0.in_ch     = ich[0];
  assign bus0.in_load   = ild[0];
  assign bus0.in_data   = idat[0];
  assign bus0.dump_req  = dreq[0];
  assign bus0.out_ready = ordy[0];
  assign ov[0]    = bus0.out_valid;
  assign och[0]   = bus0.out_ch;
  assign odat[0]  = longint'($signed(bus0.out_data));
  assign obusy[0] = bus0.busy;
  assign osat[0]  = bus0.sat_flag;

  assign bus1.in_valid  = iv[1];
  assign bus1.in_ch     = ich[1];
  assign bus1.in_load   = ild[1];
  assign bus1.in_data   = idat[1][7:0];
  assign bus1.dump_req  = dreq[1];
  assign bus1.out_ready = ordy[1];
  assign ov[1]    = bus1.out_valid;
  assign och[1]   = bus1.out_ch;
  assign odat[1]  = longint'($signed(bus1.out_data));
  assign obusy[1] = bus1.busy;
  assign osat[1]  = bus1.sat_flag;

  acumulador_multicanal #(.W(50), .NUM_CH(4), .GUARD(4), .CLR_ON_DUMP(1)) u0 (
    .clk(clk), .reset(reset), .bus(bus0));
  acumulador_multicanal #(.W(8), .NUM_CH(3), .GUARD(0), .CLR_ON_DUMP(1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  longint macc  [NI][4];
  longint snap  [NI][4];
  int     midx  [NI];
  bit     mdump [NI];
  bit     msat  [NI];

  function automatic int nch(input int g);
    return (g == 0) ? 4 : 3;
  endfunction

  function automatic int acc_w(input int g);
    return (g == 0) ? 54 : 8;
  endfunction

  function automatic longint sample_val(input int g);
    if (g == 0) return longint'($signed(idat[0]));
    else        return longint'($signed(idat[1][7:0]));
  endfunction

  // Bring an exact integer result into the AW-bit signed range
  function automatic longint fit(input int g, input longint v, output bit clamped);
    longint m, mx, mn, r;
    m  = 64'sd1 <<< acc_w(g);
    mx = (64'sd1 <<< (acc_w(g) - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (acc_w(g) - 1));
    clamped = 1'b0;
`ifdef ACUMULADOR_SAT_EN
    if (v > mx) begin r = mx; clamped = 1'b1; end
    else if (v < mn) begin r = mn; clamped = 1'b1; end
    else r = v;
`else
    r = v % m;
    if (r < 0) r += m;
    if (r > mx) r -= m;
`endif
    return r;
  endfunction

  task automatic model_step(input int g);
    longint v;
    bit     cl;
    if (!mdump[g]) begin
      if (iv[g] && (int'(ich[g]) < nch(g))) begin
        v = ild[g] ? sample_val(g) : macc[g][ich[g]] + sample_val(g);
        macc[g][ich[g]] = fit(g, v, cl);
        if (cl) msat[g] = 1'b1;
      end
      if (dreq[g]) begin
        for (int k = 0; k < 4; k++) begin
          snap[g][k] = macc[g][k];
          macc[g][k] = 0;
        end
        midx[g]  = 0;
        mdump[g] = 1'b1;
      end
    end else if (ordy[g]) begin
      midx[g]++;
      if (midx[g] == nch(g)) begin
        mdump[g] = 1'b0;
        msat[g]  = 1'b0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < NI; g++) begin
        for (int k = 0; k < 4; k++) macc[g][k] = 0;
        midx[g] = 0; mdump[g] = 1'b0; msat[g] = 1'b0;
      end
    end else begin
      for (int g = 0; g < NI; g++) model_step(g);
    end
  end

  // Compare DUT against model every cycle
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("u%0d.out_valid", g), longint'(ov[g]), longint'(mdump[g]));
      chk($sformatf("u%0d.busy", g), longint'(obusy[g]), longint'(mdump[g]));
      chk($sformatf("u%0d.sat_flag", g), longint'(osat[g]), longint'(msat[g]));
      if (mdump[g] && ov[g]) begin
        chk($sformatf("u%0d.out_ch", g), longint'(och[g]), longint'(midx[g]));
        chk($sformatf("u%0d.out_data", g), odat[g], snap[g][midx[g]]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int g, input bit v, input int ch, input bit ld,
                       input longint d, input bit dr);
    iv[g] = v; ich[g] = 2'(ch); ild[g] = ld; idat[g] = d[49:0]; dreq[g] = dr;
    @(negedge clk);
    iv[g] = 1'b0; dreq[g] = 1'b0;
  endtask

  task automatic beat(input string name, input int g, input int ch, input longint d);
    chk({name, ".valid"}, longint'(ov[g]), 1);
    chk({name, ".ch"}, longint'(och[g]), longint'(ch));
    chk({name, ".data"}, odat[g], d);
  endtask

  task automatic idle_chk(input string name, input int g);
    chk({name, ".valid"}, longint'(ov[g]), 0);
    chk({name, ".busy"}, longint'(obusy[g]), 0);
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; ich[g] = 2'd0; ild[g] = 1'b0; idat[g] = 50'd0;
      dreq[g] = 1'b0; ordy[g] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      idle_chk("reset", g);
      chk("reset.out_ch", longint'(och[g]), 0);
      chk("reset.out_data", odat[g], 0);
      chk("reset.sat", longint'(osat[g]), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Load/add on ch0, load on ch2, full-speed dump
    drive(0, 1'b1, 0, 1'b1, 100, 1'b0);
    drive(0, 1'b1, 0, 1'b0, -30, 1'b0);
    drive(0, 1'b1, 0, 1'b0, 5, 1'b0);
    drive(0, 1'b1, 2, 1'b1, -7, 1'b0);
    drive(0, 1'b0, 0, 1'b0, 0, 1'b1);
    beat("t2b0", 0, 0, 75);
    @(negedge clk); beat("t2b1", 0, 1, 0);
    @(negedge clk); beat("t2b2", 0, 2, -7);
    @(negedge clk); beat("t2b3", 0, 3, 0);
    @(negedge clk); idle_chk("t2end", 0);
    // Second dump shows the channels were cleared
    drive(0, 1'b0, 0, 1'b0, 0, 1'b1);
    beat("t2clr0", 0, 0, 0);
    @(negedge clk); beat("t2clr1", 0, 1, 0);
    @(negedge clk); beat("t2clr2", 0, 2, 0);
    repeat (2) @(negedge clk);

    // Back-pressure on beat ch1
    drive(0, 1'b1, 1, 1'b1, 42, 1'b0);
    ordy[0] = 1'b0;
    drive(0, 1'b0, 0, 1'b0, 0, 1'b1);
    beat("t3b0", 0, 0, 0);
    ordy[0] = 1'b1;
    @(negedge clk); beat("t3b1", 0, 1, 42);
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); beat("t3hold", 0, 1, 42);
    end
    ordy[0] = 1'b1;
    @(negedge clk); beat("t3b2", 0, 2, 0);
    repeat (2) @(negedge clk);
    idle_chk("t3end", 0);

    // Sample together with dump_req is reported; samples during busy are lost
    ordy[0] = 1'b0;
    drive(0, 1'b1, 1, 1'b1, 9, 1'b1);
    beat("t5b0", 0, 0, 0);
    drive(0, 1'b1, 1, 1'b1, 55, 1'b1);
    drive(0, 1'b1, 3, 1'b0, 3, 1'b0);
    beat("t5hold", 0, 0, 0);
    ordy[0] = 1'b1;
    @(negedge clk); beat("t5b1", 0, 1, 9);
    repeat (3) @(negedge clk);
    idle_chk("t5end", 0);
    drive(0, 1'b0, 0, 1'b0, 0, 1'b1);
    @(negedge clk); beat("t5after", 0, 1, 0);
    @(negedge clk); beat("t5after3", 0, 2, 0);
    @(negedge clk); beat("t5after4", 0, 3, 0);
    @(negedge clk);

    // Overflow on the narrow instance
    drive(1, 1'b1, 0, 1'b1, 127, 1'b0);
    drive(1, 1'b1, 0, 1'b0, 1, 1'b0);
`ifdef ACUMULADOR_SAT_EN
    chk("t4.sat", longint'(osat[1]), 1);
    drive(1, 1'b0, 0, 1'b0, 0, 1'b1);
    beat("t4b0", 1, 0, 127);
`else
    chk("t4.sat", longint'(osat[1]), 0);
    drive(1, 1'b0, 0, 1'b0, 0, 1'b1);
    beat("t4b0", 1, 0, -128);
`endif
    repeat (3) @(negedge clk);
    idle_chk("t4end", 1);
    chk("t4.sat_cleared", longint'(osat[1]), 0);

    // Out-of-range channel on a 3-channel instance is dropped
    drive(1, 1'b1, 1, 1'b1, 5, 1'b0);
    drive(1, 1'b1, 3, 1'b1, 99, 1'b0);
    drive(1, 1'b1, 3, 1'b0, -1, 1'b0);
    drive(1, 1'b0, 0, 1'b0, 0, 1'b1);
    beat("t6b0", 1, 0, 0);
    @(negedge clk); beat("t6b1", 1, 1, 5);
    @(negedge clk); beat("t6b2", 1, 2, 0);
    @(negedge clk); idle_chk("t6end", 1);

    // Reset in the middle of a stalled dump
    drive(0, 1'b1, 0, 1'b1, 77, 1'b0);
    ordy[0] = 1'b0;
    drive(0, 1'b0, 0, 1'b0, 0, 1'b1);
    beat("t1b0", 0, 0, 77);
    #2 reset = 1'b1;
    #1;
    idle_chk("t1rst", 0);
    chk("t1rst.out_ch", longint'(och[0]), 0);
    chk("t1rst.out_data", odat[0], 0);
    chk("t1rst.sat", longint'(osat[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    drive(0, 1'b0, 0, 1'b0, 0, 1'b1);
    beat("t1after", 0, 0, 0);
    repeat (4) @(negedge clk);
    idle_chk("t1end", 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
